// File: rtl/cteq_adapt_ctrl.sv
// -----------------------------------------------------------------------------
// cteq_adapt_ctrl
//
// Peaking-adaptation controller for the CTLE. It takes slicer data and the
// error-slicer sign, and votes only on data transitions: under-equalized
// transitions vote up, over-equalized ones vote down (sign-sign). When the
// vote accumulator reaches +/-THRESH the peaking code is stepped by one. Each
// real code change is followed by a settle window in which no votes are
// counted. This gives the DAC and CTLE time to respond before adaptation
// continues. A run of direction reversals means the loop is dithering about
// its optimum, and that sets the lock flag.
//
// Ports
//   clk          clock
//   rstb         synchronous active-low reset
//   en           adaptation enable (0 returns to IDLE, code held)
//   freeze       hold adaptation: code held, votes discarded
//   sample_valid qualifies din/err in this cycle
//   din          sliced data bit
//   err          error sign, 1 = signal magnitude above target
//   code         peaking code to the v_fz DAC (higher = more peaking)
//   code_upd     one-cycle pulse while code shows a freshly stepped value
//   locked       adaptation is dithering around its optimum
// -----------------------------------------------------------------------------
module cteq_adapt_ctrl #(
    parameter int CODE_W     = 6,
    parameter int CODE_INIT  = 32,
    parameter int CODE_MIN   = 0,
    parameter int CODE_MAX   = 63,
    parameter int ACC_W      = 8,
    parameter int THRESH     = 16,
    parameter int SETTLE_CYC = 64,
    parameter int LOCK_CNT   = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              en,
    input  logic              freeze,
    input  logic              sample_valid,
    input  logic              din,
    input  logic              err,
    output logic [CODE_W-1:0] code,
    output logic              code_upd,
    output logic              locked
);

    localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
    localparam int FLIP_W = $clog2(LOCK_CNT + 1);

    localparam logic [CODE_W-1:0]       CODE_RST    = CODE_W'(CODE_INIT);
    localparam logic [CODE_W-1:0]       CODE_LO     = CODE_W'(CODE_MIN);
    localparam logic [CODE_W-1:0]       CODE_HI     = CODE_W'(CODE_MAX);
    localparam logic [CODE_W-1:0]       CODE_ONE    = CODE_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_ZERO    = ACC_W'(0);
    localparam logic signed [ACC_W-1:0] ACC_ONE     = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_POS     = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] ACC_NEG     = -ACC_POS;
    localparam logic [CNT_W-1:0]        CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0]        CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]        SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [FLIP_W-1:0]       FLIP_ZERO   = FLIP_W'(0);
    localparam logic [FLIP_W-1:0]       FLIP_ONE    = FLIP_W'(1);
    localparam logic [FLIP_W-1:0]       FLIP_MAX    = FLIP_W'(LOCK_CNT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_FROZEN = 3'd4
    } state_t;

    state_t                   state_r, state_next_s;
    logic [CODE_W-1:0]        code_r, code_next_s;
    logic                     code_upd_r, code_upd_next_s;
    logic                     locked_r, locked_next_s;
    logic signed [ACC_W-1:0]  acc_r, acc_next_s;
    logic [CNT_W-1:0]         settle_cnt_r, settle_cnt_next_s;
    logic [FLIP_W-1:0]        flip_cnt_r, flip_cnt_next_s;
    logic                     d_prev_r, d_prev_next_s;
    logic                     d_prev_vld_r, d_prev_vld_next_s;
    logic                     last_dir_r, last_dir_next_s;
    logic                     dir_vld_r, dir_vld_next_s;

    logic                     step_req_s;
    logic                     dir_up_s;
    logic                     code_sat_s;
    logic                     vote_s;
    logic                     enter_settle_s;
    logic                     enter_update_s;

    // Saturating increment of the reversal counter.
    function automatic logic [FLIP_W-1:0] flip_inc(input logic [FLIP_W-1:0] cnt);
        if (cnt >= FLIP_MAX) begin
            return FLIP_MAX;
        end else begin
            return cnt + FLIP_ONE;
        end
    endfunction

    // The accumulator can only sit at +/-THRESH for one cycle, so its sign
    // gives the step direction when the threshold is reached.
    assign step_req_s = (acc_r == ACC_POS) || (acc_r == ACC_NEG);
    assign dir_up_s   = ~acc_r[ACC_W-1];
    assign code_sat_s = dir_up_s ? (code_r == CODE_HI) : (code_r == CODE_LO);
    assign vote_s     = sample_valid & d_prev_vld_r & (din ^ d_prev_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: en has priority over freeze, and freeze has priority over normal flow.
    always_comb begin
        state_next_s = state_r;
        if (!en) begin
            state_next_s = ST_IDLE;
        end else if (freeze && (state_r != ST_IDLE)) begin
            state_next_s = ST_FROZEN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (freeze) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_next_s = ST_ACCUM;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end
                ST_ACCUM: begin
                    if (step_req_s) begin
                        state_next_s = ST_UPDATE;
                    end else begin
                        state_next_s = ST_ACCUM;
                    end
                end
                // A real code change needs settling; a saturated step does not.
                ST_UPDATE: begin
                    if (code_upd_r) begin
                        state_next_s = ST_SETTLE;
                    end else begin
                        state_next_s = ST_ACCUM;
                    end
                end
                ST_FROZEN: state_next_s = ST_SETTLE;
                default:   state_next_s = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values. The code step is applied on the edge
    // that enters UPDATE, so code and code_upd appear one edge after the
    // threshold vote is registered.
    always_comb begin
        enter_settle_s    = (state_next_s == ST_SETTLE) && (state_r != ST_SETTLE);
        enter_update_s    = (state_next_s == ST_UPDATE);
        settle_cnt_next_s = settle_cnt_r;
        acc_next_s        = ACC_ZERO;
        d_prev_next_s     = d_prev_r;
        d_prev_vld_next_s = d_prev_vld_r;
        code_next_s       = code_r;
        code_upd_next_s   = 1'b0;
        flip_cnt_next_s   = flip_cnt_r;
        locked_next_s     = locked_r;
        last_dir_next_s   = last_dir_r;
        dir_vld_next_s    = dir_vld_r;

        if (enter_settle_s) begin
            settle_cnt_next_s = CNT_ZERO;
        end else if (state_r == ST_SETTLE) begin
            settle_cnt_next_s = settle_cnt_r + CNT_ONE;
        end else begin
            settle_cnt_next_s = settle_cnt_r;
        end

        // Votes count only while ACCUM is held. Every other path clears acc.
        if ((state_r == ST_ACCUM) && (state_next_s == ST_ACCUM)) begin
            if (vote_s) begin
                acc_next_s = err ? (acc_r - ACC_ONE) : (acc_r + ACC_ONE);
            end else begin
                acc_next_s = acc_r;
            end
        end else begin
            acc_next_s = ACC_ZERO;
        end

        if (!en) begin
            d_prev_vld_next_s = 1'b0;
        end else if (freeze) begin
            d_prev_vld_next_s = d_prev_vld_r;
        end else begin
            if (sample_valid) begin
                d_prev_next_s = din;
            end else begin
                d_prev_next_s = d_prev_r;
            end
            if (enter_settle_s) begin
                d_prev_vld_next_s = 1'b0;
            end else if (sample_valid) begin
                d_prev_vld_next_s = 1'b1;
            end else begin
                d_prev_vld_next_s = d_prev_vld_r;
            end
        end

        if (!en) begin
            flip_cnt_next_s = FLIP_ZERO;
            locked_next_s   = 1'b0;
            dir_vld_next_s  = 1'b0;
        end else if (enter_update_s) begin
            last_dir_next_s = dir_up_s;
            dir_vld_next_s  = 1'b1;
            if (code_sat_s) begin
                flip_cnt_next_s = FLIP_ZERO;
            end else begin
                code_next_s     = dir_up_s ? (code_r + CODE_ONE) : (code_r - CODE_ONE);
                code_upd_next_s = 1'b1;
                // dir_vld_r is low for the first step after IDLE, so that step never counts as a flip.
                if (dir_vld_r && (dir_up_s != last_dir_r)) begin
                    flip_cnt_next_s = flip_inc(flip_cnt_r);
                end else begin
                    flip_cnt_next_s = FLIP_ZERO;
                end
            end
            locked_next_s = (flip_cnt_next_s >= FLIP_MAX);
        end else begin
            flip_cnt_next_s = flip_cnt_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            code_r       <= CODE_RST;
            code_upd_r   <= 1'b0;
            locked_r     <= 1'b0;
            acc_r        <= ACC_ZERO;
            settle_cnt_r <= CNT_ZERO;
            flip_cnt_r   <= FLIP_ZERO;
            d_prev_r     <= 1'b0;
            d_prev_vld_r <= 1'b0;
            last_dir_r   <= 1'b0;
            dir_vld_r    <= 1'b0;
        end else begin
            code_r       <= code_next_s;
            code_upd_r   <= code_upd_next_s;
            locked_r     <= locked_next_s;
            acc_r        <= acc_next_s;
            settle_cnt_r <= settle_cnt_next_s;
            flip_cnt_r   <= flip_cnt_next_s;
            d_prev_r     <= d_prev_next_s;
            d_prev_vld_r <= d_prev_vld_next_s;
            last_dir_r   <= last_dir_next_s;
            dir_vld_r    <= dir_vld_next_s;
        end
    end

    assign code     = code_r;
    assign code_upd = code_upd_r;
    assign locked   = locked_r;

endmodule

// File: tb/tb_cteq_adapt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cteq_adapt_ctrl
//
// Directed bench for cteq_adapt_ctrl. Instance u_dut_a uses the default
// parameters. Instance u_dut_b uses CODE_INIT=1 and is used for the down-step
// and saturation case. Inputs change 1 time unit after each rising edge, and
// outputs are sampled at the same point.
//
// Timing used for the expected values. The bench counts rising edges after
// enable is raised from IDLE:
//   edge 1       IDLE -> SETTLE
//   edges 2..65  settle window (SETTLE_CYC=64), ACCUM entered at edge 65
//   edges 66..81 sixteen transition votes, so acc = +/-16 after edge 81
//   edge 82      UPDATE entered, code stepped, code_upd high
// After a saturated UPDATE the loop returns to ACCUM with no settle, so
// saturated requests repeat every 18 edges.
// -----------------------------------------------------------------------------
module tb_cteq_adapt_ctrl;

    logic       clk = 1'b0;
    logic       rstb, en, en_b, freeze, sample_valid, din, err, tog;
    logic [5:0] code, code_b;
    logic       code_upd, code_upd_b, locked, locked_b;

    int n_checks = 0;
    int n_errors = 0;
    int upd_a    = 0;
    int upd_b    = 0;
    int n;

    always #5 clk = ~clk;

    cteq_adapt_ctrl u_dut_a (
        .clk(clk), .rstb(rstb), .en(en), .freeze(freeze),
        .sample_valid(sample_valid), .din(din), .err(err),
        .code(code), .code_upd(code_upd), .locked(locked)
    );

    cteq_adapt_ctrl #(.CODE_INIT(1)) u_dut_b (
        .clk(clk), .rstb(rstb), .en(en_b), .freeze(freeze),
        .sample_valid(sample_valid), .din(din), .err(err),
        .code(code_b), .code_upd(code_upd_b), .locked(locked_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge. Count code_upd pulses, then toggle din when transitions are wanted.
    task automatic tick();
        @(posedge clk);
        #1;
        if (code_upd === 1'b1) upd_a++;
        if (code_upd_b === 1'b1) upd_b++;
        if (tog) din = ~din;
    endtask

    // Count edges until the selected code_upd is seen. Return -1 on timeout.
    task automatic wait_upd(input bit sel_b, input int max_t, output int cnt);
        bit seen;
        seen = 1'b0;
        cnt  = 0;
        while (!seen && (cnt < max_t)) begin
            tick();
            cnt++;
            seen = sel_b ? code_upd_b : code_upd;
        end
        if (!seen) cnt = -1;
    endtask

    task automatic step_a(input bit up, input int exp_code, input bit exp_lock, input string tag);
        int c;
        err = ~up;
        wait_upd(1'b0, 200, c);
        check({tag, "_seen"}, 32'(c > 0), 32'd1);
        check({tag, "_code"}, 32'(code), 32'(exp_code));
        check({tag, "_lock"}, 32'(locked), 32'(exp_lock));
    endtask

    task automatic restart_a();
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    initial begin
        rstb = 1'b0; en = 1'b0; en_b = 1'b0; freeze = 1'b0;
        sample_valid = 1'b0; din = 1'b0; err = 1'b0; tog = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_code", 32'(code), 32'd32);
        check("rst_upd", 32'(code_upd), 32'd0);
        check("rst_lock", 32'(locked), 32'd0);
        check("rst_code_b", 32'(code_b), 32'd1);
        rstb = 1'b1;
        en   = 1'b1;
        upd_a = 0;
        repeat (100) tick();
        check("idle_code", 32'(code), 32'd32);
        check("idle_upd_cnt", 32'(upd_a), 32'd0);

        // Up step latency and settle spacing
        restart_a();
        err = 1'b0; sample_valid = 1'b1; tog = 1'b1;
        wait_upd(1'b0, 200, n);
        check("up1_lat", 32'(n), 32'd82);
        check("up1_code", 32'(code), 32'd33);
        tick();
        check("up1_pulse_end", 32'(code_upd), 32'd0);
        wait_upd(1'b0, 200, n);
        check("up2_lat", 32'(n), 32'd81);
        check("up2_code", 32'(code), 32'd34);

        // No transitions, random error sign
        tog = 1'b0;
        restart_a();
        din = 1'b1;
        upd_a = 0;
        for (int i = 0; i < 300; i++) begin
            err = 1'($urandom_range(0, 1));
            tick();
        end
        check("flt_code", 32'(code), 32'd34);
        check("flt_upd_cnt", 32'(upd_a), 32'd0);

        // Freeze on the cycle acc reaches +16
        restart_a();
        err = 1'b0; tog = 1'b1;
        repeat (81) tick();
        freeze = 1'b1;
        tick();
        check("frz_code", 32'(code), 32'd34);
        check("frz_upd", 32'(code_upd), 32'd0);
        upd_a = 0;
        repeat (5) tick();
        check("frz_hold_upd", 32'(upd_a), 32'd0);
        check("frz_hold_code", 32'(code), 32'd34);
        freeze = 1'b0;
        wait_upd(1'b0, 200, n);
        check("unfrz_lat", 32'(n), 32'd82);
        check("unfrz_code", 32'(code), 32'd35);

        // Lock from alternating steps, then lost on repeated direction
        restart_a();
        step_a(1'b1, 36, 1'b0, "lk1");
        step_a(1'b0, 35, 1'b0, "lk2");
        step_a(1'b1, 36, 1'b0, "lk3");
        step_a(1'b0, 35, 1'b0, "lk4");
        step_a(1'b1, 36, 1'b1, "lk5");
        step_a(1'b1, 37, 1'b0, "lk6");
        step_a(1'b1, 38, 1'b0, "lk7");
        step_a(1'b0, 37, 1'b0, "lk8");
        step_a(1'b1, 38, 1'b0, "lk9");
        step_a(1'b0, 37, 1'b0, "lk10");
        step_a(1'b1, 38, 1'b1, "lk11");

        // Disable in the middle of ACCUM (5 votes in)
        repeat (70) tick();
        en = 1'b0;
        tick();
        check("dis_lock", 32'(locked), 32'd0);
        check("dis_code", 32'(code), 32'd38);
        check("dis_upd", 32'(code_upd), 32'd0);
        en = 1'b1;
        err = 1'b0;
        wait_upd(1'b0, 200, n);
        check("reen_lat", 32'(n), 32'd82);
        check("reen_code", 32'(code), 32'd39);
        check("reen_lock", 32'(locked), 32'd0);

        // Down step to CODE_MIN, then saturated requests with no settle in between
        en = 1'b0;
        en_b = 1'b1;
        err = 1'b1;
        wait_upd(1'b1, 200, n);
        check("dn_lat", 32'(n), 32'd82);
        check("dn_code", 32'(code_b), 32'd0);
        upd_b = 0;
        repeat (117) tick();
        check("sat_upd_cnt", 32'(upd_b), 32'd0);
        check("sat_code", 32'(code_b), 32'd0);
        err = 1'b0;
        wait_upd(1'b1, 200, n);
        check("sat_exit_lat", 32'(n), 32'd19);
        check("sat_exit_code", 32'(code_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
